vpg_param_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA pattern path: one block containing the raster timing generator and an 8-mode test-pattern generator.
- Runs directly on the pixel clock; the clock generator sits outside this block.
- Outputs are fully registered and mutually aligned: sync, data-enable, colour and frame-start strobe.
- Adds the following to the previous generation: configurable timing, configurable colour depth, sync polarity, data-enable output, frame-synchronous mode switching and an animated pattern.

---
 rtl/vpg_pkg.sv | 31 +++
 rtl/vpg_raster_timing.sv | 77 +++++++
 rtl/vpg_param_gen.sv | 213 +++++++++++++++++++++
 tb/tb_vpg_param_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vpg_pkg.sv
// Shared constants for the parametrised video pattern generator: mode codes,
// the colour-bar table and raster arithmetic helpers.
package vpg_pkg;

  localparam logic [2:0] PAT_BARS  = 3'd0;
  localparam logic [2:0] PAT_CHECK = 3'd1;
  localparam logic [2:0] PAT_RAMP  = 3'd2;
  localparam logic [2:0] PAT_BOX   = 3'd3;
  localparam logic [2:0] PAT_WHITE = 3'd4;
  localparam logic [2:0] PAT_RED   = 3'd5;
  localparam logic [2:0] PAT_GREEN = 3'd6;
  localparam logic [2:0] PAT_BLUE  = 3'd7;

  // Entry i is bar i (left to right) as {r, g, b}, one bit per channel.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vpg_raster_timing.sv
// Free-running horizontal/vertical raster counters with combinational sync, active-region,
// pixel coordinate and end-of-frame decode. Outputs are not registered here.
module vpg_raster_timing
  import vpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic          frame_end,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam int unsigned   HS_START = H_ACTIVE + H_FP;
  localparam int unsigned   HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned   VS_START = V_ACTIVE + V_FP;
  localparam int unsigned   VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   h_ext, v_ext;
  logic          h_wrap;
  logic          hs_on, vs_on;

  assign h_wrap = (h_q == H_LAST);

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_wrap) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Widen before comparing so sync windows that end exactly at the total still decode.
  assign h_ext = 32'(h_q);
  assign v_ext = 32'(v_q);

  assign hs_on     = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_on     = (v_ext >= VS_START) && (v_ext < VS_END);
  assign hs        = hs_on ? SYNC_POL : ~SYNC_POL;
  assign vs        = vs_on ? SYNC_POL : ~SYNC_POL;
  assign active    = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign frame_end = h_wrap && (v_q == V_LAST);
  assign x         = h_q;
  assign y         = v_q;

endmodule

// File: rtl/vpg_param_gen.sv
// Raster timing plus 8-mode test-pattern generator; every output is registered one clock
// after the counter state it describes, and mode/box state only change at frame boundaries.
module vpg_param_gen
  import vpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned COLOR_W    = 4,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned BOX        = 32,
  localparam int unsigned H_TOTAL   = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL   = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW        = $clog2(H_TOTAL),
  localparam int unsigned VW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         pattern_select,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_frame_start,
  output logic [COLOR_W-1:0] o_r_data,
  output logic [COLOR_W-1:0] o_g_data,
  output logic [COLOR_W-1:0] o_b_data
);

  localparam int unsigned BAR_W = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  localparam int unsigned RAMP_SH =
    ($clog2(H_ACTIVE) > COLOR_W) ? $clog2(H_ACTIVE) - COLOR_W : 0;
  localparam int unsigned BX_MAX = H_ACTIVE - BOX;
  localparam int unsigned BY_MAX = V_ACTIVE - BOX;
  localparam logic [COLOR_W-1:0] ONES = {COLOR_W{1'b1}};

  logic          hs, vs, active, frame_end;
  logic [HW-1:0] x;
  logic [VW-1:0] y;

  vpg_raster_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs),
    .vs        (vs),
    .active    (active),
    .frame_end (frame_end),
    .x         (x),
    .y         (y)
  );

  logic [2:0]    pat_q, pat_d;
  logic [HW-1:0] bx_q, bx_d;
  logic [VW-1:0] by_q, by_d;
  logic          dx_q, dx_d;  // 1 = moving toward larger coordinate
  logic          dy_q, dy_d;

  always_comb begin
    pat_d = pat_q;
    bx_d  = bx_q;
    by_d  = by_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    if (frame_end) begin
      pat_d = pattern_select;
      // A bounce reverses direction and steps back in the same update.
      if (dx_q) begin
        if (32'(bx_q) == BX_MAX) begin
          dx_d = 1'b0;
          bx_d = bx_q - HW'(1);
        end else begin
          bx_d = bx_q + HW'(1);
        end
      end else begin
        if (bx_q == '0) begin
          dx_d = 1'b1;
          bx_d = bx_q + HW'(1);
        end else begin
          bx_d = bx_q - HW'(1);
        end
      end
      if (dy_q) begin
        if (32'(by_q) == BY_MAX) begin
          dy_d = 1'b0;
          by_d = by_q - VW'(1);
        end else begin
          by_d = by_q + VW'(1);
        end
      end else begin
        if (by_q == '0) begin
          dy_d = 1'b1;
          by_d = by_q + VW'(1);
        end else begin
          by_d = by_q - VW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PAT_BARS;
      bx_q  <= '0;
      by_q  <= '0;
      dx_q  <= 1'b1;
      dy_q  <= 1'b1;
    end else begin
      pat_q <= pat_d;
      bx_q  <= bx_d;
      by_q  <= by_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
    end
  end

  logic [31:0]        x_ext, y_ext, bx_ext, by_ext;
  logic [31:0]        bar_idx, ramp_full;
  logic [2:0]         bar_sel, bar_rgb;
  logic [COLOR_W-1:0] ramp;
  logic               in_box, check_on;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  assign x_ext     = 32'(x);
  assign y_ext     = 32'(y);
  assign bx_ext    = 32'(bx_q);
  assign by_ext    = 32'(by_q);
  assign bar_idx   = x_ext / BAR_W;
  assign bar_sel   = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
  assign bar_rgb   = BAR_RGB[bar_sel];
  assign ramp_full = x_ext >> RAMP_SH;
  assign ramp      = (ramp_full > 32'(ONES)) ? ONES : ramp_full[COLOR_W-1:0];
  assign check_on  = x_ext[CHECK_LOG2] ^ y_ext[CHECK_LOG2];
  assign in_box    = (x_ext >= bx_ext) && (x_ext < bx_ext + BOX) &&
                     (y_ext >= by_ext) && (y_ext < by_ext + BOX);

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    unique case (pat_q)
      PAT_BARS: begin
        r_d = {COLOR_W{bar_rgb[2]}};
        g_d = {COLOR_W{bar_rgb[1]}};
        b_d = {COLOR_W{bar_rgb[0]}};
      end
      PAT_CHECK: begin
        r_d = check_on ? ONES : '0;
        g_d = check_on ? ONES : '0;
        b_d = check_on ? ONES : '0;
      end
      PAT_RAMP: begin
        r_d = ramp;
        g_d = ramp;
        b_d = ramp;
      end
      PAT_BOX: begin
        r_d = in_box ? ONES : '0;
        g_d = in_box ? ONES : '0;
        b_d = ONES;
      end
      PAT_WHITE: begin
        r_d = ONES;
        g_d = ONES;
        b_d = ONES;
      end
      PAT_RED:   r_d = ONES;
      PAT_GREEN: g_d = ONES;
      PAT_BLUE:  b_d = ONES;
      default: ;
    endcase
    if (!active) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_hs          <= ~SYNC_POL;
      o_vs          <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_r_data      <= '0;
      o_g_data      <= '0;
      o_b_data      <= '0;
    end else begin
      o_hs          <= hs;
      o_vs          <= vs;
      o_de          <= active;
      o_frame_start <= active && (x == '0) && (y == '0);
      o_r_data      <= r_d;
      o_g_data      <= g_d;
      o_b_data      <= b_d;
    end
  end

endmodule

// File: tb/tb_vpg_param_gen.sv
// Directed bench for vpg_param_gen: default timing and bars, a reduced raster with active-high
// sync for frame-level behaviour, and a tiny raster for box motion.
module tb_vpg_param_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       rst_d = 1'b1, rst_m = 1'b1, rst_s = 1'b1;
  logic [2:0] ps_d = 3'd0, ps_m = 3'd0, ps_s = 3'd3;

  logic       d_hs, d_vs, d_de, d_fs;
  logic [3:0] d_r, d_g, d_b;
  logic       m_hs, m_vs, m_de, m_fs;
  logic [3:0] m_r, m_g, m_b;
  logic       s_hs, s_vs, s_de, s_fs;
  logic [3:0] s_r, s_g, s_b;
  logic [11:0] d_rgb, m_rgb, s_rgb;

  assign d_rgb = {d_r, d_g, d_b};
  assign m_rgb = {m_r, m_g, m_b};
  assign s_rgb = {s_r, s_g, s_b};

  vpg_param_gen dut_d (
    .clk(clk), .rst(rst_d), .pattern_select(ps_d),
    .o_hs(d_hs), .o_vs(d_vs), .o_de(d_de), .o_frame_start(d_fs),
    .o_r_data(d_r), .o_g_data(d_g), .o_b_data(d_b)
  );

  // 80 x 32 total raster, active-high sync.
  vpg_param_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .SYNC_POL(1'b1), .CHECK_LOG2(3), .BOX(8)
  ) dut_m (
    .clk(clk), .rst(rst_m), .pattern_select(ps_m),
    .o_hs(m_hs), .o_vs(m_vs), .o_de(m_de), .o_frame_start(m_fs),
    .o_r_data(m_r), .o_g_data(m_g), .o_b_data(m_b)
  );

  // 19 x 15 total raster.
  vpg_param_gen #(
    .H_ACTIVE(16), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BOX(4)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pattern_select(ps_s),
    .o_hs(s_hs), .o_vs(s_vs), .o_de(s_de), .o_frame_start(s_fs),
    .o_r_data(s_r), .o_g_data(s_g), .o_b_data(s_b)
  );

  initial begin
    int hs_first, hs_first1, hs_cnt, de_cnt, fs_extra;
    int vs_first, vs_cnt, fs_cnt, de_m, white_bad, blank_bad;
    int wx, wy, wcnt, f, p, h, v, ebx, eby;

    // ---------------- default configuration ----------------
    repeat (3) @(negedge clk);
    check("d_rst_de", d_de, 0);
    check("d_rst_hs", d_hs, 1);
    check("d_rst_vs", d_vs, 1);
    check("d_rst_fs", d_fs, 0);
    check("d_rst_rgb", d_rgb, 0);
    rst_d = 1'b0;

    hs_first = -1; hs_first1 = -1; hs_cnt = 0; de_cnt = 0; fs_extra = 0;
    for (int t = 0; t <= 1700; t++) begin
      @(negedge clk);
      if (t < 800) begin
        if (d_de) de_cnt++;
        if (!d_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = t;
        end
      end else if (t < 1600 && !d_hs && hs_first1 < 0) begin
        hs_first1 = t;
      end
      if (d_fs && t != 0) fs_extra++;
      case (t)
        0: begin
          check("d_first_de", d_de, 1);
          check("d_first_fs", d_fs, 1);
          check("d_bar_x0", d_rgb, 12'hFFF);
        end
        80:   check("d_bar_x80", d_rgb, 12'hFF0);
        159:  check("d_bar_x159", d_rgb, 12'hFF0);
        160:  check("d_bar_x160", d_rgb, 12'h0FF);
        560:  check("d_bar_x560", d_rgb, 12'h000);
        639: begin
          check("d_bar_x639", d_rgb, 12'h000);
          check("d_de_x639", d_de, 1);
        end
        640: begin
          check("d_de_x640", d_de, 0);
          check("d_blank_x640", d_rgb, 12'h000);
        end
        1700: check("d_line2_x100", d_rgb, 12'hFF0);
        default: ;
      endcase
    end
    check("d_hs_first", hs_first, 656);
    check("d_hs_width", hs_cnt, 96);
    check("d_de_per_line", de_cnt, 640);
    check("d_hs_period", hs_first1, 800 + 656);
    check("d_fs_extra", fs_extra, 0);

    // Mid-line reset while showing active video.
    rst_d = 1'b1;
    @(negedge clk);
    check("d_mrst_de", d_de, 0);
    check("d_mrst_rgb", d_rgb, 0);
    check("d_mrst_hs", d_hs, 1);
    check("d_mrst_fs", d_fs, 0);
    rst_d = 1'b0;
    @(negedge clk);
    check("d_restart_fs", d_fs, 1);
    check("d_restart_rgb", d_rgb, 12'hFFF);

    // ---------------- reduced raster, active-high sync ----------------
    @(negedge clk);
    check("m_rst_hs", m_hs, 0);
    check("m_rst_vs", m_vs, 0);
    check("m_rst_de", m_de, 0);
    rst_m = 1'b0;

    vs_first = -1; vs_cnt = 0; fs_cnt = 0; de_m = 0; white_bad = 0; blank_bad = 0;
    hs_first = -1; hs_cnt = 0;
    for (int t = 0; t <= 14950; t++) begin
      @(negedge clk);
      if (!m_de && m_rgb != 12'h000) blank_bad++;
      if (m_fs) fs_cnt++;
      if (t < 2560 && m_vs) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t;
      end
      if (t < 80 && m_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = t;
      end
      if (t >= 2560 && t < 5120 && m_de) begin
        de_m++;
        if (m_rgb != 12'hFFF) white_bad++;
      end
      case (t)
        1600:  check("m_hold_x0", m_rgb, 12'hFFF);
        1608:  check("m_hold_x8", m_rgb, 12'hFF0);
        2560:  check("m_fs_frame1", m_fs, 1);
        2568:  check("m_white_x8", m_rgb, 12'hFFF);
        5120:  check("m_chk_0_0", m_rgb, 12'h000);
        5128:  check("m_chk_8_0", m_rgb, 12'hFFF);
        5768:  check("m_chk_8_8", m_rgb, 12'h000);
        7700:  check("m_ramp_x20", m_rgb, 12'h555);
        7743:  check("m_ramp_x63", m_rgb, 12'hFFF);
        10563: check("m_box_3_4", m_rgb, 12'h00F);
        10564: check("m_box_4_4", m_rgb, 12'hFFF);
        11131: check("m_box_11_11", m_rgb, 12'hFFF);
        11132: check("m_box_12_11", m_rgb, 12'h00F);
        12805: check("m_red_x5", m_rgb, 12'hF00);
        14950: begin
          check("m_pre_hs", m_hs, 1);
          check("m_pre_vs", m_vs, 1);
        end
        default: ;
      endcase
      case (t)
        800:   ps_m = 3'd4;
        2660:  ps_m = 3'd1;
        5220:  ps_m = 3'd2;
        7780:  ps_m = 3'd3;
        10340: ps_m = 3'd5;
        default: ;
      endcase
    end
    check("m_vs_first", vs_first, 26 * 80);
    check("m_vs_width", vs_cnt, 160);
    check("m_hs_first", hs_first, 68);
    check("m_hs_width", hs_cnt, 8);
    check("m_fs_count", fs_cnt, 6);
    check("m_de_frame1", de_m, 1536);
    check("m_white_bad", white_bad, 0);
    check("m_blank_bad", blank_bad, 0);

    // Reset during vertical and horizontal sync.
    rst_m = 1'b1;
    @(negedge clk);
    check("m_mrst_hs", m_hs, 0);
    check("m_mrst_vs", m_vs, 0);
    check("m_mrst_de", m_de, 0);
    check("m_mrst_fs", m_fs, 0);
    check("m_mrst_rgb", m_rgb, 0);
    @(negedge clk);
    rst_m = 1'b0;
    @(negedge clk);
    check("m_restart_de", m_de, 1);
    check("m_restart_fs", m_fs, 1);
    check("m_restart_rgb", m_rgb, 12'hFFF);
    repeat (8) @(negedge clk);
    check("m_restart_bars_x8", m_rgb, 12'hFF0);

    // ---------------- tiny raster, box motion ----------------
    rst_s = 1'b0;
    wx = -1; wy = -1; wcnt = 0;
    for (int t = 0; t < 21 * 285; t++) begin
      @(negedge clk);
      f = t / 285;
      p = t % 285;
      h = p % 19;
      v = p / 19;
      if (p == 0) begin
        wx = -1; wy = -1; wcnt = 0;
      end
      if (s_de && s_rgb == 12'hFFF) begin
        if (wx < 0) begin
          wx = h;
          wy = v;
        end
        wcnt++;
      end
      if (f == 1 && v == 11 && h == 15) check("s_bg_blue", s_rgb, 12'h00F);
      if (f >= 1 && p == 284) begin
        ebx = (f <= 12) ? f : 24 - f;
        eby = (f <= 8) ? f : ((f <= 16) ? 16 - f : f - 16);
        check($sformatf("s_white_cnt_f%0d", f), wcnt, 16);
        check($sformatf("s_bx_f%0d", f), wx, ebx);
        check($sformatf("s_by_f%0d", f), wy, eby);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
